// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - carry-pipelined carry-lookahead adder/subtractor
// One lookahead group per stage; group carry registered into the next stage.
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / GROUP;

    if (GROUP < 1 || GROUP > 8 || (WIDTH % GROUP) != 0) begin : g_param_check
        $fatal(1, "pipelined_cla_adder: GROUP must be 1..8 and divide WIDTH");
    end

    // Every carry is a flat sum of products over g/p and the group carry-in.
    function automatic logic [GROUP:0] lookahead(
        input logic [GROUP-1:0] g,
        input logic [GROUP-1:0] p,
        input logic             ci
    );
        logic [GROUP:0] c;
        logic           t;
        c    = '0;
        c[0] = ci;
        for (int j = 0; j < GROUP; j++) begin
            t = ci;
            for (int m = 0; m <= j; m++) t = t & p[m];
            c[j+1] = t;
            for (int k = 0; k <= j; k++) begin
                t = g[k];
                for (int m = k + 1; m <= j; m++) t = t & p[m];
                c[j+1] = c[j+1] | t;
            end
        end
        return c;
    endfunction

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub ? 1'b1 : cin;

    for (genvar i = 0; i < NG; i++) begin : g_stage
        localparam int PW = WIDTH - GROUP * i;

        logic [PW-1:0]          pend_a;
        logic [PW-1:0]          pend_b;
        logic                   gc;
        logic                   gv;
        logic [GROUP:0]         carry;
        logic [GROUP-1:0]       gsum;
        logic [GROUP*(i+1)-1:0] nx_r;
        logic [GROUP*(i+1)-1:0] q_r;
        logic                   q_v;
        logic                   q_c;

        if (i == 0) begin : g_src
            assign pend_a = a;
            assign pend_b = b_eff;
            assign gc     = c0;
            assign gv     = in_valid;
            assign nx_r   = gsum;
        end else begin : g_src
            assign pend_a = g_stage[i-1].g_pend.q_a;
            assign pend_b = g_stage[i-1].g_pend.q_b;
            assign gc     = g_stage[i-1].q_c;
            assign gv     = g_stage[i-1].q_v;
            assign nx_r   = {gsum, g_stage[i-1].q_r};
        end

        assign carry = lookahead(pend_a[GROUP-1:0] & pend_b[GROUP-1:0],
                                 pend_a[GROUP-1:0] | pend_b[GROUP-1:0], gc);
        assign gsum  = pend_a[GROUP-1:0] ^ pend_b[GROUP-1:0] ^ carry[GROUP-1:0];

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                q_v <= 1'b0;
                q_c <= 1'b0;
                q_r <= '0;
            end else if (en) begin
                q_v <= gv;
                q_c <= carry[GROUP];
                q_r <= nx_r;
            end
        end

        if (i < NG - 1) begin : g_pend
            // Only operand groups not yet resolved travel down the pipe.
            logic [PW-GROUP-1:0] q_a;
            logic [PW-GROUP-1:0] q_b;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    q_a <= '0;
                    q_b <= '0;
                end else if (en) begin
                    q_a <= pend_a[PW-1:GROUP];
                    q_b <= pend_b[PW-1:GROUP];
                end
            end
        end else begin : g_tail
            logic q_cm;
            logic q_z;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    q_cm <= 1'b0;
                    q_z  <= 1'b0;
                end else if (en) begin
                    q_cm <= carry[GROUP-1];
                    q_z  <= (nx_r == '0);
                end
            end

            assign out_valid = q_v;
            assign result    = q_r;
            assign cout      = q_c;
            assign ovf       = q_c ^ q_cm;
            assign zero      = q_z;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - scoreboard bench for pipelined_cla_adder
// Directed vectors on the 32/8 instance; random sweep on 8/8 and 16/4 instances.
module tb_pipelined_cla_adder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
    logic [31:0] a, b, result;

    logic        iv8, ir8, cin8, sub8, ov8, or8, co8, of8, z8;
    logic [7:0]  a8, b8, r8;
    logic        iv16, ir16, cin16, sub16, ov16, or16, co16, of16, z16;
    logic [15:0] a16, b16, r16;

    int checks = 0;
    int failures = 0;
    int stall_cnt = 0;
    int irlow_cnt = 0;
    int ov_cnt = 0;
    logic sweep_on = 1'b0;
    logic rnd_on = 1'b0;
    logic was_stalled = 1'b0;
    logic [34:0] held;
    logic [34:0] sb[$];
    logic [34:0] sb8[$];
    logic [34:0] sb16[$];

    pipelined_cla_adder #(.WIDTH(32), .GROUP(8)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ovf(ovf), .zero(zero)
    );

    pipelined_cla_adder #(.WIDTH(8), .GROUP(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8),
        .result(r8), .cout(co8), .ovf(of8), .zero(z8)
    );

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut16 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16),
        .result(r16), .cout(co16), .ovf(of16), .zero(z16)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [34:0] pk(input logic [31:0] r, input logic c, input logic v,
                                       input logic z);
        return {z, v, c, r};
    endfunction

    // Behavioural reference: plain modular A+B' arithmetic at width w.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic s, input int w);
        logic [63:0] mask, xx, bb, full, r;
        logic        co, v;
        mask = (64'd1 << w) - 64'd1;
        xx   = {32'h0, x} & mask;
        bb   = (s ? ~{32'h0, y} : {32'h0, y}) & mask;
        full = xx + bb + (s ? 64'd1 : {63'd0, ci});
        r    = full & mask;
        co   = full[w];
        v    = (xx[w-1] == bb[w-1]) && (r[w-1] != xx[w-1]);
        return {(r == 64'd0), v, co, r[31:0]};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic ci,
                        input logic s, input logic push, input logic [34:0] e);
        int guard;
        guard    = 0;
        a        = x;
        b        = y;
        cin      = ci;
        sub      = s;
        in_valid = 1'b1;
        forever begin
            @(negedge clock);
            if (in_ready) begin
                if (push) sb.push_back(e);
                break;
            end
            guard++;
            if (guard > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout in_ready stuck low for %0d cycles", guard);
                break;
            end
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 50) begin
            @(negedge clock);
            n++;
            if (out_valid) break;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string nm);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        chk(nm, sb.size(), 0);
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        logic [34:0] e;
        if (!reset_n) begin
            was_stalled = 1'b0;
        end else begin
            chk("in_ready", in_ready, !out_valid || out_ready);
            if (was_stalled) chk("hold_stable", {out_valid, zero, ovf, cout, result}, {1'b1, held});
            if (out_valid && !out_ready) stall_cnt++;
            if (!in_ready) irlow_cnt++;
            if (out_valid) ov_cnt++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out result=%h with empty queue", result);
                end else begin
                    e = sb.pop_front();
                    chk("result_flags", {zero, ovf, cout, result}, e);
                end
            end
            was_stalled = out_valid && !out_ready;
            held        = {zero, ovf, cout, result};
        end
    end

    always @(negedge clock) begin
        logic [34:0] e;
        if (reset_n) begin
            if (iv8 && ir8) sb8.push_back(model({24'h0, a8}, {24'h0, b8}, cin8, sub8, 8));
            if (iv16 && ir16) sb16.push_back(model({16'h0, a16}, {16'h0, b16}, cin16, sub16, 16));
            if (ov8 && or8) begin
                if (sb8.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out8 result=%h", r8);
                end else begin
                    e = sb8.pop_front();
                    chk("sweep8", {z8, of8, co8, 24'h0, r8}, e);
                end
            end
            if (ov16 && or16) begin
                if (sb16.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out16 result=%h", r16);
                end else begin
                    e = sb16.pop_front();
                    chk("sweep16", {z16, of16, co16, 16'h0, r16}, e);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (sweep_on) begin
                iv8   = ($urandom_range(0, 3) != 0);
                a8    = 8'($urandom);
                b8    = 8'($urandom);
                cin8  = 1'($urandom);
                sub8  = 1'($urandom);
                or8   = ($urandom_range(0, 3) != 0);
                iv16  = ($urandom_range(0, 3) != 0);
                a16   = 16'($urandom);
                b16   = 16'($urandom);
                cin16 = 1'($urandom);
                sub16 = 1'($urandom);
                or16  = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] x, y;
        logic ci, s;
        reset_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; or8 = 1'b1;
        iv16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; or16 = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_outputs", {out_valid, result, cout, ovf, zero}, 0);
        #2;
        reset_n = 1'b1;
        @(negedge clock);
        chk("ready_after_reset", in_ready, 1);
        @(posedge clock);
        #1;

        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, pk(32'h0, 1'b1, 1'b0, 1'b1));
        wait_valid(n);
        chk("latency_ng4", n, 4);
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, pk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
        send(32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1, pk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
        send(32'd5, 32'd7, 1'b1, 1'b1, 1'b1, pk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
        drain("drain_directed");

        stall_cnt = 0;
        irlow_cnt = 0;
        fork
            begin
                send(32'd1, 32'd2, 1'b0, 1'b0, 1'b1, pk(32'd3, 1'b0, 1'b0, 1'b0));
                send(32'd10, 32'd20, 1'b1, 1'b0, 1'b1, pk(32'd31, 1'b0, 1'b0, 1'b0));
                send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1,
                     pk(32'h2345_6789, 1'b0, 1'b0, 1'b0));
                send(32'd100, 32'd100, 1'b0, 1'b1, 1'b1, pk(32'h0, 1'b1, 1'b0, 1'b1));
                send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1,
                     pk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0));
                send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1,
                     pk(32'h0, 1'b1, 1'b1, 1'b1));
            end
            begin
                for (int k = 0; k < 50; k++) begin
                    @(negedge clock);
                    if (out_valid) break;
                end
                @(posedge clock);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");
        chk("stall_cycles", stall_cnt, 3);
        chk("in_ready_low_cycles", irlow_cnt, 3);

        out_ready = 1'b0;
        send(32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 35'h0);
        wait_valid(n);
        chk("stalled_valid_before_reset", out_valid, 1);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("async_reset_outputs", {out_valid, result, cout, ovf, zero}, 0);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        send(32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 35'h0);
        send(32'd5, 32'd6, 1'b0, 1'b0, 1'b0, 35'h0);
        send(32'd7, 32'd8, 1'b0, 1'b0, 1'b0, 35'h0);
        #2;
        reset_n = 1'b0;
        ov_cnt = 0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        chk("no_out_after_midflight_reset", ov_cnt, 0);
        send(32'h0000_FFFF, 32'h0001_0001, 1'b0, 1'b0, 1'b1, pk(32'h0002_0000, 1'b0, 1'b0, 1'b0));
        wait_valid(n);
        chk("latency_after_reset", n, 4);
        drain("drain_after_reset");

        rnd_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    x  = $urandom;
                    y  = $urandom;
                    ci = 1'($urandom);
                    s  = 1'($urandom);
                    send(x, y, ci, s, 1'b1, model(x, y, ci, s, 32));
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clock);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("drain_random");

        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
        @(negedge clock);
        chk("ready8", ir8, 1);
        @(posedge clock);
        #1;
        iv8 = 1'b0;
        @(negedge clock);
        chk("latency_ng1", {ov8, r8, co8}, {1'b1, 8'h00, 1'b1});
        @(posedge clock);
        sweep_on = 1'b1;
        repeat (12000) @(posedge clock);
        sweep_on = 1'b0;
        #1;
        iv8 = 1'b0; or8 = 1'b1; iv16 = 1'b0; or16 = 1'b1;
        repeat (20) @(posedge clock);
        chk("drain_sweep8", sb8.size(), 0);
        chk("drain_sweep16", sb16.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
